// File: rtl/sp_mailbox.sv
// sp_mailbox: Wishbone byte mailbox with a TX FIFO toward the host and an RX FIFO from it.
// Define SP_MAILBOX_TIMER_EN to add the 32-bit cycle counter and its coherent-read latch at offsets 4..7.
module sp_mailbox #(
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:23] wb_adr_i,
  input  logic [0:7]  wb_dat_i,
  output logic [0:7]  wb_dat_o,
  input  logic        wb_we_i,
  input  logic [0:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic [0:7]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  input  logic [0:7]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic        irq_o
);
  localparam int AW    = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;

  logic [2:0] reg_a;
  logic [7:0] wdat;
  logic       accept;
  logic       act;
  logic       unused_adr;
  logic [7:0] rd_val;
  logic       tx_ovf;
  logic       rx_ovf;

  assign reg_a      = wb_adr_i[21:23];
  assign wdat       = wb_dat_i;
  assign accept     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign act        = accept & wb_sel_i[0];
  assign unused_adr = &{1'b0, wb_adr_i[0:20]};

  // FIFO index 0 is TX (bus -> host), index 1 is RX (host -> bus).
  logic [1:0]         f_push;
  logic [1:0]         f_pop;
  logic [1:0]         f_full;
  logic [1:0]         f_empty;
  logic [1:0][7:0]    f_wdata;
  logic [1:0][7:0]    f_rdata;
  logic [1:0][AW:0]   f_count;

  assign f_push[0]  = act & wb_we_i & (reg_a == 3'd0);
  assign f_pop[0]   = tx_ready_i;
  assign f_wdata[0] = wdat;
  assign f_push[1]  = rx_valid_i;
  assign f_pop[1]   = act & ~wb_we_i & (reg_a == 3'd0);
  assign f_wdata[1] = rx_data_i;

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    // Full/empty are pre-edge, so a pop never makes room for a same-edge push.
    assign push_ok = f_push[g] & ~f_full[g];
    assign pop_ok  = f_pop[g] & ~f_empty[g];

    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) begin
          mem[wr_ptr] <= f_wdata[g];
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (pop_ok) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (push_ok != pop_ok) begin
          count <= push_ok ? count + 1'b1 : count - 1'b1;
        end
      end
    end

    assign f_rdata[g] = mem[rd_ptr];
    assign f_count[g] = count;
    assign f_full[g]  = count[AW];
    assign f_empty[g] = (count == '0);
  end

  assign tx_valid_o = ~f_empty[0];
  assign tx_data_o  = f_rdata[0];
  assign rx_ready_o = ~f_full[1];
  assign irq_o      = ~f_empty[1];

`ifdef SP_MAILBOX_TIMER_EN
  logic [31:0] cyc_cnt;
  logic [31:0] tmr_latch;

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt   <= '0;
      tmr_latch <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (act && !wb_we_i && reg_a == 3'd4) begin
        tmr_latch <= cyc_cnt;
      end
    end
  end
`endif

  always_comb begin
    rd_val = 8'h00;
    if (wb_sel_i[0] && !wb_we_i) begin
      case (reg_a)
        3'd0: rd_val = f_empty[1] ? 8'h00 : f_rdata[1];
        3'd1: rd_val = {3'b000, tx_ovf, rx_ovf, f_empty[0], f_full[0], ~f_empty[1]};
        3'd2: rd_val = 8'(f_count[1]);
        3'd3: rd_val = 8'(f_count[0]);
`ifdef SP_MAILBOX_TIMER_EN
        // Offset 4 returns the live MSB byte while the latch captures the whole word.
        3'd4: rd_val = cyc_cnt[31:24];
        3'd5: rd_val = tmr_latch[23:16];
        3'd6: rd_val = tmr_latch[15:8];
        3'd7: rd_val = tmr_latch[7:0];
`endif
        default: rd_val = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= 8'h00;
      tx_ovf   <= 1'b0;
      rx_ovf   <= 1'b0;
    end else begin
      wb_ack_o <= accept;
      if (accept) begin
        wb_dat_o <= rd_val;
      end
      if (act && wb_we_i && reg_a == 3'd1 && wdat[4]) begin
        tx_ovf <= 1'b0;
      end
      if (act && wb_we_i && reg_a == 3'd0 && f_full[0]) begin
        tx_ovf <= 1'b1;
      end
      if (act && wb_we_i && reg_a == 3'd1 && wdat[3]) begin
        rx_ovf <= 1'b0;
      end
      // A fresh overflow on the same edge as a clear wins.
      if (rx_valid_i && f_full[1]) begin
        rx_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sp_mailbox.sv
// tb_sp_mailbox: directed scenarios plus a randomized run against a queue-based mailbox model.
module tb_sp_mailbox;
  localparam int DEPTH = 16;
`ifdef SP_MAILBOX_TIMER_EN
  localparam bit TIMER_ON = 1'b1;
`else
  localparam bit TIMER_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [0:23] wb_adr_i = '0;
  logic [0:7]  wb_dat_i = '0;
  logic [0:7]  wb_dat_o;
  logic        wb_we_i = 1'b0;
  logic [0:0]  wb_sel_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_ack_o;
  logic [0:7]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b0;
  logic [0:7]  rx_data_i = '0;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o;
  logic        irq_o;

  sp_mailbox #(.FIFO_DEPTH_LOG2(4)) dut (
    .clk(clk), .reset(reset),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i), .wb_stb_i(wb_stb_i),
    .wb_cyc_i(wb_cyc_i), .wb_ack_o(wb_ack_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  // Reference cycle count: zero out of reset, +1 every clock.
  logic [31:0] tb_cyc = '0;
  always @(posedge clk) begin
    if (reset) tb_cyc <= '0;
    else       tb_cyc <= tb_cyc + 32'd1;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called at a negedge; returns at the negedge after the ack cycle.
  task automatic bus(input logic [2:0] a, input logic we, input logic [7:0] d,
                     input logic sel, input logic hold, output logic [7:0] rd);
    wb_adr_i = {21'd0, a};
    wb_we_i  = we;
    wb_dat_i = d;
    wb_sel_i = sel;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    @(negedge clk);
    check("ack", wb_ack_o, 1'b1);
    rd = wb_dat_o;
    if (!hold) begin
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
    end
    @(negedge clk);
    check("ack_single", wb_ack_o, 1'b0);
  endtask

  logic [7:0]  rd;
  logic [31:0] t0;
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  logic        m_tx_ovf, m_rx_ovf, ack_now, chk_dat, req, accept, sel, we;
  logic [31:0] m_latch;
  logic [7:0]  exp_dat, nd, d;
  logic [2:0]  a;
  int          tx_n, rx_n;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ack", wb_ack_o, 1'b0);
    check("rst_dat", wb_dat_o, 8'h00);
    check("rst_txv", tx_valid_o, 1'b0);
    check("rst_rxr", rx_ready_o, 1'b1);
    check("rst_irq", irq_o, 1'b0);
    reset = 1'b0;
    bus(3'd1, 1'b0, 8'h00, 1'b1, 1'b0, rd); check("rst_status", rd, 8'h04);

    // Three writes stalled, then drained on consecutive cycles
    tx_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) bus(3'd0, 1'b1, 8'h41 + 8'(i), 1'b1, 1'b0, rd);
    bus(3'd3, 1'b0, 8'h00, 1'b1, 1'b0, rd); check("txcnt3", rd, 8'd3);
    tx_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("drain_v", tx_valid_o, 1'b1);
      check("drain_d", tx_data_o, 8'h41 + 8'(i));
      @(negedge clk);
    end
    check("drain_empty", tx_valid_o, 1'b0);
    tx_ready_i = 1'b0;

    // Overfill TX: 17th byte dropped, tx_ovf sticky until cleared
    for (int i = 0; i < 17; i++) bus(3'd0, 1'b1, 8'h60 + 8'(i), 1'b1, 1'b0, rd);
    bus(3'd3, 1'b0, 8'h00, 1'b1, 1'b0, rd); check("txcnt16", rd, 8'd16);
    // tx_ovf = 0x10, tx_full = 0x02
    bus(3'd1, 1'b0, 8'h00, 1'b1, 1'b0, rd); check("status_ovf", rd, 8'h12);
    bus(3'd1, 1'b1, 8'h10, 1'b1, 1'b0, rd);
    bus(3'd1, 1'b0, 8'h00, 1'b1, 1'b0, rd); check("status_clr", rd, 8'h02);
    tx_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("full_drain", tx_data_o, 8'h60 + 8'(i));
      @(negedge clk);
    end
    check("full_drain_empty", tx_valid_o, 1'b0);
    tx_ready_i = 1'b0;

    // Host push, irq, pop, read of empty RX
    rx_valid_i = 1'b1; rx_data_i = 8'h5A;
    @(negedge clk);
    rx_valid_i = 1'b0;
    check("irq_set", irq_o, 1'b1);
    bus(3'd2, 1'b0, 8'h00, 1'b1, 1'b0, rd); check("rxcnt1", rd, 8'd1);
    bus(3'd0, 1'b0, 8'h00, 1'b1, 1'b0, rd); check("rx_pop", rd, 8'h5A);
    check("irq_clr", irq_o, 1'b0);
    bus(3'd0, 1'b0, 8'h00, 1'b1, 1'b0, rd); check("rx_underflow", rd, 8'h00);
    bus(3'd0, 1'b1, 8'hEE, 1'b0, 1'b0, rd); check("sel0_wr", rd, 8'h00);
    check("sel0_no_push", tx_valid_o, 1'b0);

    // Timer bytes read back-to-back with stb held
    t0 = tb_cyc;
    bus(3'd4, 1'b0, 8'h00, 1'b1, 1'b1, rd); check("tmr4", rd, TIMER_ON ? t0[31:24] : 8'h00);
    bus(3'd5, 1'b0, 8'h00, 1'b1, 1'b1, rd); check("tmr5", rd, TIMER_ON ? t0[23:16] : 8'h00);
    bus(3'd6, 1'b0, 8'h00, 1'b1, 1'b1, rd); check("tmr6", rd, TIMER_ON ? t0[15:8] : 8'h00);
    bus(3'd7, 1'b0, 8'h00, 1'b1, 1'b0, rd); check("tmr7", rd, TIMER_ON ? t0[7:0] : 8'h00);

    // Reset in the ack cycle of a DATA read
    for (int i = 0; i < 2; i++) begin
      rx_valid_i = 1'b1; rx_data_i = 8'hA0 + 8'(i);
      @(negedge clk);
    end
    rx_valid_i = 1'b0;
    bus(3'd2, 1'b0, 8'h00, 1'b1, 1'b0, rd); check("rxcnt2", rd, 8'd2);
    wb_adr_i = '0; wb_we_i = 1'b0; wb_sel_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(negedge clk);
    check("mid_ack", wb_ack_o, 1'b1);
    reset = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge clk);
    check("mid_rst_ack", wb_ack_o, 1'b0);
    check("mid_rst_irq", irq_o, 1'b0);
    reset = 1'b0;
    bus(3'd2, 1'b0, 8'h00, 1'b1, 1'b0, rd); check("mid_rst_rxcnt", rd, 8'd0);

    // Simultaneous RX push and pop at occupancy 5
    for (int i = 0; i < 5; i++) begin
      rx_valid_i = 1'b1; rx_data_i = 8'h10 + 8'(i);
      @(negedge clk);
    end
    rx_valid_i = 1'b0;
    bus(3'd2, 1'b0, 8'h00, 1'b1, 1'b0, rd); check("rxcnt5", rd, 8'd5);
    rx_valid_i = 1'b1; rx_data_i = 8'h15;
    wb_adr_i = '0; wb_we_i = 1'b0; wb_sel_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(negedge clk);
    rx_valid_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    check("pp_ack", wb_ack_o, 1'b1);
    check("pp_dat", wb_dat_o, 8'h10);
    @(negedge clk);
    bus(3'd2, 1'b0, 8'h00, 1'b1, 1'b0, rd); check("pp_rxcnt", rd, 8'd5);
    for (int i = 0; i < 5; i++) begin
      bus(3'd0, 1'b0, 8'h00, 1'b1, 1'b0, rd); check("pp_order", rd, 8'h11 + 8'(i));
    end

    // Randomized run from a clean reset against the queue model
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tx_q.delete(); rx_q.delete();
    m_tx_ovf = 1'b0; m_rx_ovf = 1'b0; m_latch = '0;
    ack_now = 1'b0; chk_dat = 1'b0; exp_dat = '0;
    for (int i = 0; i < 800; i++) begin
      check("r_ack", wb_ack_o, ack_now);
      if (ack_now && chk_dat) check("r_dat", wb_dat_o, exp_dat);
      check("r_txv", tx_valid_o, tx_q.size() != 0);
      if (tx_q.size() != 0) check("r_txd", tx_data_o, tx_q[0]);
      check("r_rxr", rx_ready_o, rx_q.size() < DEPTH);
      check("r_irq", irq_o, rx_q.size() != 0);

      rx_valid_i = ($urandom_range(0, 2) == 0);
      rx_data_i  = 8'($urandom);
      tx_ready_i = ($urandom_range(0, 3) == 0);
      req = $urandom_range(0, 1) != 0;
      a   = ($urandom_range(0, 9) < 4) ? 3'd0 : 3'($urandom_range(1, 7));
      we  = $urandom_range(0, 1) != 0;
      sel = $urandom_range(0, 7) != 0;
      d   = 8'($urandom);
      wb_adr_i = {21'd0, a}; wb_we_i = we; wb_dat_i = d; wb_sel_i = sel;
      wb_cyc_i = req;
      wb_stb_i = req | ($urandom_range(0, 1) != 0);

      accept = req && !ack_now;
      tx_n = tx_q.size();
      rx_n = rx_q.size();
      nd = 8'h00;
      if (accept && sel && !we) begin
        case (a)
          3'd0: nd = (rx_n != 0) ? rx_q[0] : 8'h00;
          3'd1: nd = {3'b000, m_tx_ovf, m_rx_ovf, tx_n == 0, tx_n == DEPTH, rx_n != 0};
          3'd2: nd = 8'(rx_n);
          3'd3: nd = 8'(tx_n);
          3'd4: nd = TIMER_ON ? tb_cyc[31:24] : 8'h00;
          3'd5: nd = TIMER_ON ? m_latch[23:16] : 8'h00;
          3'd6: nd = TIMER_ON ? m_latch[15:8] : 8'h00;
          default: nd = TIMER_ON ? m_latch[7:0] : 8'h00;
        endcase
      end
      if (tx_n != 0 && tx_ready_i) void'(tx_q.pop_front());
      if (accept && sel && we && a == 3'd0) begin
        if (tx_n == DEPTH) m_tx_ovf = 1'b1;
        else tx_q.push_back(d);
      end
      if (accept && sel && !we && a == 3'd0 && rx_n != 0) void'(rx_q.pop_front());
      if (accept && sel && we && a == 3'd1) begin
        if (d[4]) m_tx_ovf = 1'b0;
        if (d[3]) m_rx_ovf = 1'b0;
      end
      if (rx_valid_i) begin
        if (rx_n == DEPTH) m_rx_ovf = 1'b1;
        else rx_q.push_back(rx_data_i);
      end
      if (accept && sel && !we && a == 3'd4) m_latch = tb_cyc;
      ack_now = accept;
      chk_dat = accept && !we;
      exp_dat = nd;
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
